// File: rtl/clock_divider.sv
// clock_divider: programmable divided clock with rise/fall strobes and load/ack ratio handshake; CLKDIV_GLITCHFREE_EN defers in-run ratio changes to the period wrap
module clock_divider #(
  parameter int CNT_W = 8
) (
  input  logic             clkIn,
  input  logic             resetN,
  input  logic             enable,
  input  logic [CNT_W-1:0] divIn,
  input  logic             divLoad,
  output logic             divAck,
  output logic             busy,
  output logic             clkOut,
  output logic             riseStb,
  output logic             fallStb
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, div, div_n, div_c;
  logic [CNT_W:0] h_w;
  logic busy_n, ack_n, clk_n, rise_n, fall_n, wrap;
`ifdef CLKDIV_GLITCHFREE_EN
  logic [CNT_W-1:0] pend, pend_n;
`endif
  assign div_c = (divIn < CNT_W'(2)) ? CNT_W'(2) : divIn;
  assign wrap = cnt == div - 1'b1;
  always_ff @(posedge clkIn or negedge resetN)
    if (!resetN) begin
      state <= IDLE;
      cnt <= '0;
      div <= CNT_W'(2);
      busy <= 1'b0;
      divAck <= 1'b0;
      clkOut <= 1'b0;
      riseStb <= 1'b0;
      fallStb <= 1'b0;
`ifdef CLKDIV_GLITCHFREE_EN
      pend <= CNT_W'(2);
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      div <= div_n;
      busy <= busy_n;
      divAck <= ack_n;
      clkOut <= clk_n;
      riseStb <= rise_n;
      fallStb <= fall_n;
`ifdef CLKDIV_GLITCHFREE_EN
      pend <= pend_n;
`endif
    end
  always_comb begin
    state_n = state;
    cnt_n = '0;
    div_n = div;
    busy_n = busy;
    ack_n = 1'b0;
    clk_n = 1'b0;
    rise_n = 1'b0;
    fall_n = 1'b0;
    h_w = '0;
`ifdef CLKDIV_GLITCHFREE_EN
    pend_n = pend;
`endif
    if (state == IDLE) begin
      if (divLoad) begin
        div_n = div_c;
        ack_n = 1'b1;
      end
      if (enable) begin
        state_n = RUN;
        clk_n = 1'b1;
        rise_n = 1'b1;
      end
    end else if (!enable) begin
      state_n = IDLE;
      fall_n = clkOut;
`ifdef CLKDIV_GLITCHFREE_EN
      if (divLoad || busy) begin
        div_n = divLoad ? div_c : pend;
        busy_n = 1'b0;
        ack_n = 1'b1;
      end
`else
      if (divLoad) begin
        div_n = div_c;
        ack_n = 1'b1;
      end
`endif
    end else begin
`ifdef CLKDIV_GLITCHFREE_EN
      cnt_n = wrap ? '0 : cnt + 1'b1;
      if (wrap && busy) begin
        div_n = pend;
        busy_n = 1'b0;
        ack_n = 1'b1;
      end
      if (divLoad) begin
        pend_n = div_c;
        busy_n = 1'b1;
      end
`else
      cnt_n = (wrap || divLoad) ? '0 : cnt + 1'b1;
      if (divLoad) begin
        div_n = div_c;
        ack_n = 1'b1;
      end
`endif
      h_w = ({1'b0, div_n} + 1'b1) >> 1;
      clk_n = {1'b0, cnt_n} < h_w;
      rise_n = cnt_n == '0;
      fall_n = {1'b0, cnt_n} == h_w;
    end
  end
endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider: scoreboard bench comparing {divAck,busy,clkOut,riseStb,fallStb} each cycle against the divider's expected waveform
module tb_clock_divider;
  localparam int CNT_W = 8;
  logic clkIn = 1'b0, resetN = 1'b0, enable = 1'b0, divLoad = 1'b0;
  logic [CNT_W-1:0] divIn = '0;
  logic divAck, busy, clkOut, riseStb, fallStb;
  typedef struct {string tag; logic [4:0] v;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_pass = 0;
  logic last;
  clock_divider #(.CNT_W(CNT_W)) dut (
    .clkIn(clkIn), .resetN(resetN), .enable(enable), .divIn(divIn), .divLoad(divLoad),
    .divAck(divAck), .busy(busy), .clkOut(clkOut), .riseStb(riseStb), .fallStb(fallStb)
  );
  always #5 clkIn = ~clkIn;
  function automatic logic [4:0] obs();
    return {divAck, busy, clkOut, riseStb, fallStb};
  endfunction
  function automatic logic [4:0] ph(int k, int n);
    int p = k % n;
    int h = (n + 1) / 2;
    return {2'b00, logic'(p < h), logic'(p == 0), logic'(p == h)};
  endfunction
  task automatic check(string tag, logic [4:0] got, logic [4:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (ack,busy,clk,rise,fall)", tag, got, exp);
  endtask
  task automatic cyc(string tag, logic [4:0] e);
    exp_t x;
    sb.push_back('{tag, e});
    @(posedge clkIn);
    #1;
    x = sb.pop_front();
    check(x.tag, obs(), x.v);
  endtask
  task automatic load_idle(int n);
    divIn = CNT_W'(n);
    divLoad = 1'b1;
    cyc("idle_load", 5'b10000);
    divLoad = 1'b0;
  endtask
  task automatic run(string tag, int n, int cycles, output logic lst);
    logic [4:0] e;
    enable = 1'b1;
    for (int k = 0; k < cycles; k++) cyc(tag, ph(k, n));
    e = ph(cycles - 1, n);
    lst = e[2];
  endtask
  task automatic stop(logic lst);
    enable = 1'b0;
    cyc("exit", {4'b0000, lst});
    cyc("idle", 5'b00000);
    cyc("idle", 5'b00000);
  endtask
  initial begin
    #12;
    check("reset", obs(), 5'b00000);
    @(negedge clkIn);
    resetN = 1'b1;
    load_idle(4); run("n4", 4, 8, last); stop(last);
    load_idle(5); run("n5", 5, 10, last); stop(last);
    load_idle(0); run("n0", 2, 4, last); stop(last);
    load_idle(1); run("n1", 2, 4, last); stop(last);
    load_idle(3); run("n3", 3, 6, last); stop(last);
    load_idle(255); run("n255", 255, 130, last); stop(last);
    load_idle(8); run("n8_drop", 8, 3, last); stop(last);
    load_idle(6); run("n6", 6, 3, last);
    divIn = 8'd3;
    divLoad = 1'b1;
`ifdef CLKDIV_GLITCHFREE_EN
    cyc("gf_load", 5'b01001);
    divLoad = 1'b0;
    cyc("gf_pend", 5'b01000);
    cyc("gf_pend", 5'b01000);
    cyc("gf_wrap", 5'b10110);
`else
    cyc("imm_load", 5'b10110);
    divLoad = 1'b0;
`endif
    for (int k = 1; k <= 6; k++) cyc("n3_after", ph(k, 3));
    stop(1'b1);
`ifdef CLKDIV_GLITCHFREE_EN
    load_idle(6); run("n6b", 6, 2, last);
    divIn = 8'd3;
    divLoad = 1'b1;
    cyc("gf_busy", 5'b01100);
    divLoad = 1'b0;
    enable = 1'b0;
    cyc("gf_drop", 5'b10001);
    cyc("idle", 5'b00000);
    run("n3_drop", 3, 6, last); stop(last);
`endif
    load_idle(6); run("n6c", 6, 2, last);
    divIn = 8'd3;
    divLoad = 1'b1;
`ifdef CLKDIV_GLITCHFREE_EN
    cyc("pre_reset", 5'b01100);
`else
    cyc("pre_reset", 5'b10110);
`endif
    divLoad = 1'b0;
    #2 resetN = 1'b0;
    #1 check("async_reset", obs(), 5'b00000);
    enable = 1'b0;
    @(negedge clkIn);
    resetN = 1'b1;
    run("post_reset", 2, 4, last); stop(last);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/clock_divider.md
# clock_divider

Programmable integer clock divider: the counterpart to the clock doubler, producing a slower clock from the system clock instead of a faster one. Generates a registered divided clock `clkOut`, plus one-cycle rise/fall strobes for logic that must stay in the `clkIn` domain. Ratio changes use a load/acknowledge handshake. Sits between the board clock and the processor's slow-stepping and display logic.

## Interface
- `CNT_W`, default 8: width of ratio and phase counter.
- `clkIn`  in  1  system clock; all state updates on its rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run divider; low forces idle.
- `divIn`  in  CNT_W  requested divide ratio N.
- `divLoad`  in  1  one-cycle request to adopt `divIn`.
- `divAck`  out  1  one-cycle pulse when a new ratio takes effect.
- `busy`  out  1  a loaded ratio is pending, not yet applied.
- `clkOut`  out  1  divided clock, registered.
- `riseStb`  out  1  high in the cycle `clkOut` goes 0→1.
- `fallStb`  out  1  high in the cycle `clkOut` goes 1→0.

## Operation
- **Reset values:** active ratio N=2, pending ratio 2, phase counter `cnt`=0, state IDLE; `clkOut`, `riseStb`, `fallStb`, `divAck` and `busy` are all 0.
- **Ratio clamp:** a ratio below 2 (`divIn`=0 or 1) is stored as 2.
- **High time:** H = (N+1)>>1. Odd N gives one extra high cycle.
- **States:**
  - IDLE → RUN on a rising edge with `enable`=1.
  - RUN → IDLE on any edge with `enable`=0.
- **IDLE:** `cnt`=0, `clkOut`=0.
- **RUN:**
  - `cnt` increments each edge and wraps from N-1 to 0.
  - `clkOut` is registered as (next `cnt` < H).
  - `riseStb` is registered as (next `cnt` == 0).
  - `fallStb` is registered as (next `cnt` == H).
- **IDLE→RUN entry:** next `cnt`=0, so `clkOut`=1 and `riseStb`=1.
- **RUN→IDLE exit:** if `clkOut` was 1, `fallStb`=1 for that cycle. No `riseStb` is ever issued on exit.
- **Ratio load:** `divLoad` is sampled on each edge; `divIn` is clamped and captured on that same edge.
- **Reset mid-operation:** all state returns to the reset values immediately, regardless of any pending load.

## Timing
- Output period is exactly N `clkIn` cycles.
  - High for H cycles, low for N-H cycles.
  - Exactly one `riseStb` and one `fallStb` per period.
- Enable-to-first-`clkOut`-rise latency: 1 edge.
- Disable-to-`clkOut`-low latency: 1 edge.
- `divAck` is always a single-cycle pulse; `busy` is 0 whenever no load is pending.
- **Load while IDLE:** applied on the capturing edge; `divAck` rises on the same edge, regardless of configuration.

## Configuration
- `CLKDIV_GLITCHFREE_EN` **undefined (immediate mode):**
  - A load in RUN is applied on the capturing edge, with `divAck` on that edge.
  - `cnt` restarts at 0, so `clkOut`=1 and `riseStb`=1 on that edge.
  - A short period may result. `busy` stays 0.
- `CLKDIV_GLITCHFREE_EN` **defined (glitch-free mode):**
  - A load in RUN stores a pending ratio and sets `busy`=1.
  - The pending ratio is applied on the wrap edge (`cnt` N-1→0); `divAck`=1 on that edge and `busy` clears.
  - A second `divLoad` while `busy` overwrites the pending value; only one `divAck` is issued.
  - A load on the same edge as a wrap is not applied until the next wrap.
  - If `enable` drops while `busy`, the pending ratio is applied on entry to IDLE, with `divAck` on that edge.

## Test plan
- Reset, then `divIn`=4 with `divLoad` while IDLE, then `enable`=1 → `divAck` on the load edge; `clkOut` repeats 1,1,0,0; `riseStb` every 4th cycle starting on the enable edge; `fallStb` 2 cycles later.
- `divIn`=5 → `clkOut` high 3 cycles, low 2; period 5.
- `divIn`=0 and `divIn`=1 → behave as N=2: `clkOut` toggles every cycle; both strobes pulse alternately.
- Run at N=6, load 3 at `cnt`=2:
  - Immediate mode → `divAck` on the same edge; `clkOut` restarts high; period 3 thereafter.
  - Glitch-free mode → `busy`=1 until the `cnt` 5→0 wrap; `divAck` on that wrap; no period shorter than 6 before the switch.
- Drop `enable` while `clkOut`=1 at N=8 → next edge `clkOut`=0 and `fallStb`=1; no further strobes.
- Assert `resetN`=0 mid-period with a pending load (glitch-free mode) → all outputs 0 immediately; after release and `enable`, period is 2.
